// File: rtl/mesh_result_checker_if.sv
// Result-checker bus: start/mode/pattern and mesh results in, check status out.
// Master drives the request and the mesh results; slave is the checker.
interface mesh_result_checker_if #(
  parameter int N          = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 6
);
  localparam int RW = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CW = $clog2(N + 1);
  localparam int IW = $clog2(N);

  logic                  start;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] pattern;
  logic [N*RW-1:0]       results_flat;
  logic                  busy;
  logic                  done;
  logic                  pass;
  logic [CW-1:0]         err_count;
  logic [IW-1:0]         first_err_idx;
  logic [N-1:0]          err_mask;

  modport master (
    output start, mode, pattern, results_flat,
    input  busy, done, pass, err_count, first_err_idx, err_mask
  );

  modport slave (
    input  start, mode, pattern, results_flat,
    output busy, done, pass, err_count, first_err_idx, err_mask
  );
endinterface

// File: rtl/mesh_result_checker.sv
// On-chip self-check for the mesh sorter: settle, scan LANES PEs per cycle,
// compare against the expected permutation and report errors.
module mesh_result_checker #(
  parameter int N           = 64,
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 6,
  parameter int LANES       = 8,
  parameter int WAIT_CYCLES = 53
) (
  input logic clk,
  input logic rst,
  mesh_result_checker_if.slave bus
);
  localparam int RW    = ADDR_WIDTH + DATA_WIDTH + 1;
  localparam int CW    = $clog2(N + 1);
  localparam int IW    = $clog2(N);
  localparam int SCANS = N / LANES;
  localparam int SW    = (SCANS > 1) ? $clog2(SCANS) : 1;
  localparam int WW    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                state;
  logic [WW-1:0]         wcnt;
  logic [SW-1:0]         scnt;
  logic [1:0]            mode_q;
  logic [DATA_WIDTH-1:0] pattern_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  pass_q;
  logic [CW-1:0]         err_count_q;
  logic [IW-1:0]         first_q;
  logic [N-1:0]          mask_q;

  logic [LANES-1:0]      lane_err;
  logic [CW-1:0]         lane_cnt;
  logic [IW-1:0]         lane_first;
  logic                  hit;
  logic [DATA_WIDTH-1:0] exp_d;
  logic [RW-1:0]         exp_r;
  int                    base;
  int                    k;
  logic [CW-1:0]         cnt_next;

  // Lane compare; lanes are scanned low to high so the first hit is the lowest index
  always_comb begin
    lane_err   = '0;
    lane_cnt   = '0;
    lane_first = '0;
    hit        = 1'b0;
    exp_d      = '0;
    exp_r      = '0;
    k          = 0;
    base       = int'(scnt) * LANES;
    for (int l = 0; l < LANES; l++) begin
      k = base + l;
      unique case (mode_q)
        2'd1:    exp_d = DATA_WIDTH'(k);
        2'd2:    exp_d = pattern_q;
        default: exp_d = DATA_WIDTH'(N - 1 - k);
      endcase
      exp_r = {1'b0, ADDR_WIDTH'(k), exp_d};
      if (bus.results_flat[k*RW +: RW] != exp_r) begin
        lane_err[l] = 1'b1;
        lane_cnt    = lane_cnt + CW'(1);
        if (!hit) begin
          hit        = 1'b1;
          lane_first = IW'(k);
        end
      end
    end
  end

  assign cnt_next = err_count_q + lane_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      wcnt        <= '0;
      scnt        <= '0;
      mode_q      <= '0;
      pattern_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      first_q     <= '0;
      mask_q      <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state       <= S_WAIT;
            wcnt        <= '0;
            mode_q      <= bus.mode;
            pattern_q   <= bus.pattern;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            first_q     <= '0;
            mask_q      <= '0;
          end
        end
        S_WAIT: begin
          if (wcnt == WW'(WAIT_CYCLES - 1)) begin
            state <= S_SCAN;
            scnt  <= '0;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        S_SCAN: begin
          mask_q      <= mask_q | (N'(lane_err) << base);
          err_count_q <= cnt_next;
          if (err_count_q == '0 && hit) begin
            first_q <= lane_first;
          end
          if (scnt == SW'(SCANS - 1)) begin
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            pass_q <= (cnt_next == '0);
          end else begin
            scnt <= scnt + SW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_idx = first_q;
  assign bus.err_mask      = mask_q;
endmodule

// File: tb/tb_mesh_result_checker.sv
// Directed bench for mesh_result_checker: three builds (LANES 8, 1, 64)
// share clock, reset and mesh results.
module tb_mesh_result_checker;
  localparam int N  = 64;
  localparam int RW = 13;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start8 = 1'b0;
  logic           start_x = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [5:0]     pattern = 6'd0;
  logic [N*RW-1:0] rf = '0;

  int tests = 0;
  int fails = 0;
  int bad_excl = 0;
  int l1, l8, l64, lx;

  always #5 clk = ~clk;

  mesh_result_checker_if #(.N(N), .ADDR_WIDTH(6), .DATA_WIDTH(6)) b8 ();
  mesh_result_checker_if #(.N(N), .ADDR_WIDTH(6), .DATA_WIDTH(6)) b1 ();
  mesh_result_checker_if #(.N(N), .ADDR_WIDTH(6), .DATA_WIDTH(6)) b64 ();

  assign b8.start         = start8;
  assign b8.mode          = mode;
  assign b8.pattern       = pattern;
  assign b8.results_flat  = rf;
  assign b1.start         = start_x;
  assign b1.mode          = mode;
  assign b1.pattern       = pattern;
  assign b1.results_flat  = rf;
  assign b64.start        = start_x;
  assign b64.mode         = mode;
  assign b64.pattern      = pattern;
  assign b64.results_flat = rf;

  mesh_result_checker #(.LANES(8), .WAIT_CYCLES(53)) dut8 (
    .clk(clk), .rst(rst), .bus(b8.slave));
  mesh_result_checker #(.LANES(1), .WAIT_CYCLES(53)) dut1 (
    .clk(clk), .rst(rst), .bus(b1.slave));
  mesh_result_checker #(.LANES(64), .WAIT_CYCLES(53)) dut64 (
    .clk(clk), .rst(rst), .bus(b64.slave));

  always @(negedge clk) begin
    if (b8.done && b8.busy) bad_excl++;
    if (!b8.done && b8.pass) bad_excl++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_rev();
    for (int k = 0; k < N; k++)
      rf[k*RW +: RW] = {1'b0, 6'(k), 6'(63 - k)};
  endtask

  task automatic fill_pat(input logic [5:0] p);
    for (int k = 0; k < N; k++)
      rf[k*RW +: RW] = {1'b0, 6'(k), p};
  endtask

  // Start at edge T, then count edges after T until done (or stop_at).
  task automatic run(input bit all, input int pa, input int pb,
                     input int stop_at, output int o1, output int o8,
                     output int o64);
    o1 = -1; o8 = -1; o64 = -1;
    @(negedge clk);
    start8 = 1'b1;
    start_x = all;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start_x = 1'b0;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      start8 = (e == pa) || (e == pb);
      if (o8 < 0 && b8.done) o8 = e;
      if (o1 < 0 && b1.done) o1 = e;
      if (o64 < 0 && b64.done) o64 = e;
      if (e == stop_at) break;
      if (o8 > 0 && (!all || (o1 > 0 && o64 > 0))) break;
    end
    start8 = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int e = 1; e <= 200; e++) begin
      @(posedge clk);
      #1;
      if (b8.done) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(b8.busy), 64'd0);
    chk({tag, "_done"}, 64'(b8.done), 64'd0);
    chk({tag, "_pass"}, 64'(b8.pass), 64'd0);
    chk({tag, "_cnt"}, 64'(b8.err_count), 64'd0);
    chk({tag, "_first"}, 64'(b8.first_err_idx), 64'd0);
    chk({tag, "_mask"}, 64'(b8.err_mask), 64'd0);
  endtask

  initial begin
    fill_rev();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // mode 0, correct reverse-sorted mesh, all three builds
    mode = 2'd0;
    run(1'b1, 0, 0, 0, l1, l8, l64);
    chk("t1_lat8", 64'(l8), 64'd61);
    chk("t1_lat1", 64'(l1), 64'd117);
    chk("t1_lat64", 64'(l64), 64'd54);
    chk("t1_pass8", 64'(b8.pass), 64'd1);
    chk("t1_cnt8", 64'(b8.err_count), 64'd0);
    chk("t1_mask8", 64'(b8.err_mask), 64'd0);
    chk("t1_pass1", 64'(b1.pass), 64'd1);
    chk("t1_pass64", 64'(b64.pass), 64'd1);

    // PE 5 data zeroed, PE 40 valid_n set
    fill_rev();
    rf[5*RW +: RW] = {1'b0, 6'd5, 6'd0};
    rf[40*RW + 12] = 1'b1;
    run(1'b0, 0, 0, 0, l1, l8, l64);
    chk("t2_lat", 64'(l8), 64'd61);
    chk("t2_pass", 64'(b8.pass), 64'd0);
    chk("t2_cnt", 64'(b8.err_count), 64'd2);
    chk("t2_first", 64'(b8.first_err_idx), 64'd5);
    chk("t2_mask", 64'(b8.err_mask), (64'd1 << 5) | (64'd1 << 40));

    // mode 1 against reverse data: every PE mismatches
    fill_rev();
    mode = 2'd1;
    run(1'b0, 0, 0, 0, l1, l8, l64);
    chk("t3_cnt", 64'(b8.err_count), 64'd64);
    chk("t3_first", 64'(b8.first_err_idx), 64'd0);
    chk("t3_mask", 64'(b8.err_mask), {64{1'b1}});
    chk("t3_pass", 64'(b8.pass), 64'd0);

    // mode 2 constant pattern; restart clears the previous 64 errors
    fill_pat(6'h2A);
    mode = 2'd2;
    pattern = 6'h2A;
    run(1'b0, 0, 0, 5, l1, l8, l64);
    chk("t4_wbusy", 64'(b8.busy), 64'd1);
    chk("t4_wdone", 64'(b8.done), 64'd0);
    chk("t4_wcnt", 64'(b8.err_count), 64'd0);
    chk("t4_wmask", 64'(b8.err_mask), 64'd0);
    wait_done(lx);
    chk("t4_lat", 64'(lx + 5), 64'd61);
    chk("t4_pass", 64'(b8.pass), 64'd1);
    chk("t4_cnt", 64'(b8.err_count), 64'd0);
    // mode 0 on pattern data: only PE 21 (63-21 = 0x2A) matches
    mode = 2'd0;
    pattern = 6'd0;
    run(1'b0, 0, 0, 0, l1, l8, l64);
    chk("t4b_cnt", 64'(b8.err_count), 64'd63);
    chk("t4b_first", 64'(b8.first_err_idx), 64'd0);
    chk("t4b_mask", 64'(b8.err_mask), ~(64'd1 << 21));

    // start pulses in WAIT and on the last SCAN cycle are ignored
    fill_rev();
    mode = 2'd0;
    run(1'b0, 10, 60, 0, l1, l8, l64);
    chk("t5_lat", 64'(l8), 64'd61);
    chk("t5_pass", 64'(b8.pass), 64'd1);
    @(posedge clk);
    #1;
    chk("t5_hold", 64'(b8.done), 64'd1);
    chk("t5_hbusy", 64'(b8.busy), 64'd0);

    // reset in the middle of a failing scan
    mode = 2'd1;
    run(1'b0, 0, 0, 57, l1, l8, l64);
    chk("t5_mcnt", 64'(b8.err_count), 64'd32);
    chk("t5_mbusy", 64'(b8.busy), 64'd1);
    rst = 1'b1;
    #1;
    chk_zero("t5_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("excl", 64'(bad_excl), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
